// File: rtl/fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_add_arbiter
// Purpose  : Round-robin sharing of one combinational FP adder between two
//            requesters, with registered operands and a valid/ready response.
// Revision : 1.0
// ============================================================================
module fpu_add_arbiter #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_overflow,
    input  logic             add_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    logic             r_id;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_overflow;
    logic             r_rsp_underflow;

    logic             w_accept_window;
    logic             w_grant;
    logic             w_fire;
    logic [1:0]       w_req_ready;

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        w_accept_window = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
        w_grant         = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        w_fire          = w_accept_window && (req_valid != 2'b00);
        w_req_ready     = 2'b00;
        if (w_fire) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_fire) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = w_fire ? EXEC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_last_grant    <= 1'b1;
            r_id            <= 1'b0;
            r_tag           <= '0;
            r_add_a         <= '0;
            r_add_b         <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= 1'b0;
            r_rsp_tag       <= '0;
            r_rsp_result    <= '0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_underflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_fire) begin
                r_add_a      <= w_grant ? req1_a   : req0_a;
                r_add_b      <= w_grant ? req1_b   : req0_b;
                r_tag        <= w_grant ? req1_tag : req0_tag;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            // The adder has had the whole EXEC cycle to settle on r_add_a/b.
            if (r_state == EXEC) begin
                r_rsp_valid     <= 1'b1;
                r_rsp_id        <= r_id;
                r_rsp_tag       <= r_tag;
                r_rsp_result    <= add_result;
                r_rsp_overflow  <= add_overflow;
                r_rsp_underflow <= add_underflow;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready     = w_req_ready;
    assign add_a         = r_add_a;
    assign add_b         = r_add_b;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_tag       = r_rsp_tag;
    assign rsp_result    = r_rsp_result;
    assign rsp_overflow  = r_rsp_overflow;
    assign rsp_underflow = r_rsp_underflow;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_add_arbiter
// Purpose  : Self-checking bench for fpu_add_arbiter with a stub adder and a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fpu_add_arbiter;

    typedef struct {logic [63:0] a; logic [63:0] b; logic [3:0] tag;} req_t;
    typedef struct {int e; logic id;} hs_t;
    typedef struct {int e; logic id; logic [3:0] tag; logic [63:0] res; logic ovf; logic unf;} rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic [63:0] add_a, add_b, add_result;
    logic        add_overflow, add_underflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
    logic [63:0] rsp_result;
    logic        rsp_overflow, rsp_underflow, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    req_t q0[$];
    req_t q1[$];
    hs_t  hs_log[$];
    rsp_t rsp_log[$];
    logic [1:0] hs = 2'b00;
    logic prev_rv = 1'b0;

    // Reference model: expected visible state after the most recent edge.
    logic        m_exec = 1'b0, m_rv = 1'b0, m_last = 1'b1;
    logic        m_txn_id = 1'b0, m_rsp_id = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    logic [3:0]  m_txn_tag = '0, m_rsp_tag = '0;
    logic [63:0] m_add_a = '0, m_add_b = '0, m_res = '0;

    fpu_add_arbiter #(.WIDTH(64), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_tag(req0_tag), .req1_tag(req1_tag),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .add_overflow(add_overflow), .add_underflow(add_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow), .busy(busy)
    );

    // Stand-in for the shared adder: exact answers for the IEEE vectors used
    // here, otherwise an integer sum with flags taken from low operand bits.
    function automatic logic [65:0] fadd(input logic [63:0] a, input logic [63:0] b);
        if (a == 64'h3FF0000000000000 && b == 64'h4000000000000000)
            return {2'b00, 64'h4008000000000000};
        if (a == 64'h7FEFFFFFFFFFFFFF && b == 64'h7FEFFFFFFFFFFFFF)
            return {2'b10, 64'h7FF0000000000000};
        return {a[1] & b[1], a[0] & b[0], a + b};
    endfunction

    always_comb {add_overflow, add_underflow, add_result} = fadd(add_a, add_b);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: presents queue heads, retiring an entry after its handshake.
    initial forever begin
        @(posedge clk);
        cyc++;
        #2;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        if (q0.size() > 0) begin
            req_valid[0] = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_tag = q0[0].tag;
        end else req_valid[0] = 1'b0;
        if (q1.size() > 0) begin
            req_valid[1] = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_tag = q1[0].tag;
        end else req_valid[1] = 1'b0;
    end

    // Compare process: check outputs, log events, then advance the model
    // with the inputs the next rising edge will see.
    initial begin
        logic win, g, fire;
        logic [1:0] exp_rr;
        logic [65:0] sum;
        forever begin
            @(negedge clk);
            win    = (!m_exec && !m_rv) || (m_rv && rsp_ready);
            g      = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            fire   = win && (req_valid != 2'b00);
            exp_rr = fire ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rr});
            chk("add_a", add_a, m_add_a);
            chk("add_b", add_b, m_add_b);
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rv});
            chk("busy", {63'd0, busy}, {63'd0, m_exec | m_rv});
            if (m_rv) begin
                chk("rsp_id", {63'd0, rsp_id}, {63'd0, m_rsp_id});
                chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, m_rsp_tag});
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_flags", {62'd0, rsp_overflow, rsp_underflow}, {62'd0, m_ovf, m_unf});
            end
            hs = req_valid & req_ready & {2{~rst}};
            if (hs != 2'b00) hs_log.push_back('{cyc + 1, hs[1]});
            if (rsp_valid && !prev_rv)
                rsp_log.push_back('{cyc + 1, rsp_id, rsp_tag, rsp_result, rsp_overflow, rsp_underflow});
            prev_rv = rsp_valid;
            if (rst) begin
                m_exec = 1'b0; m_rv = 1'b0; m_last = 1'b1;
                m_add_a = '0; m_add_b = '0; m_res = '0;
                m_rsp_id = 1'b0; m_rsp_tag = '0; m_ovf = 1'b0; m_unf = 1'b0;
            end else begin
                if (m_exec) begin
                    sum = fadd(m_add_a, m_add_b);
                    m_rv = 1'b1; m_rsp_id = m_txn_id; m_rsp_tag = m_txn_tag;
                    m_res = sum[63:0]; m_ovf = sum[65]; m_unf = sum[64];
                end else if (m_rv && rsp_ready) begin
                    m_rv = 1'b0;
                end
                m_exec = fire;
                if (fire) begin
                    m_txn_id  = g;
                    m_txn_tag = g ? req1_tag : req0_tag;
                    m_add_a   = g ? req1_a : req0_a;
                    m_add_b   = g ? req1_b : req0_b;
                    m_last    = g;
                end
            end
        end
    end

    task automatic push(input int r, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        if (r == 0) q0.push_back('{a, b, tag});
        else        q1.push_back('{a, b, tag});
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && !m_exec && !m_rv) && n < 200);
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hb, rb, k, n;
        repeat (3) step();
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_add_a", add_a, 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        chk("reset_rsp_tag", {60'd0, rsp_tag}, 64'd0);
        chk("reset_req_ready", {62'd0, req_ready}, 64'd0);

        // Contention: four requests each, alternating grants starting at 0
        step();
        rsp_ready = 1'b1;
        hb = hs_log.size(); rb = rsp_log.size();
        for (int i = 0; i < 4; i++) begin
            push(0, 64'(16 * i + 4), 64'(i + 8), 4'(1 + i));
            push(1, 64'(16 * i + 64), 64'(i + 12), 4'(9 + i));
        end
        wait_drain();
        chk("cont_grants", 64'(hs_log.size() - hb), 64'd8);
        chk("cont_rsps", 64'(rsp_log.size() - rb), 64'd8);
        for (int i = 0; i < 8 && hb + i < hs_log.size() && rb + i < rsp_log.size(); i++) begin
            chk("cont_grant_order", {63'd0, hs_log[hb + i].id}, 64'(i % 2));
            chk("cont_rsp_id", {63'd0, rsp_log[rb + i].id}, 64'(i % 2));
            chk("cont_rsp_tag", {60'd0, rsp_log[rb + i].tag}, 64'((i % 2) ? 9 + i / 2 : 1 + i / 2));
            if (i > 0) chk("cont_spacing", 64'(rsp_log[rb + i].e - rsp_log[rb + i - 1].e), 64'd2);
        end

        // Single request 1.0 + 2.0
        step();
        push(0, 64'h3FF0000000000000, 64'h4000000000000000, 4'h5);
        wait_drain();
        if (hs_log.size() > 0 && rsp_log.size() > 0) begin
            chk("single_latency", 64'(rsp_log[$].e - hs_log[$].e), 64'd2);
            chk("single_result", rsp_log[$].res, 64'h4008000000000000);
            chk("single_id", {63'd0, rsp_log[$].id}, 64'd0);
            chk("single_tag", {60'd0, rsp_log[$].tag}, 64'h5);
            chk("single_flags", {62'd0, rsp_log[$].ovf, rsp_log[$].unf}, 64'd0);
        end

        // Backpressure with requester 1 pending
        step();
        rsp_ready = 1'b0;
        push(0, 64'h10, 64'h20, 4'h7);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL bp_timeout: rsp_valid=0, required 1");
        end
        push(1, 64'h100, 64'h200, 4'h8);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_result", rsp_result, 64'h30);
            chk("bp_rsp_tag", {60'd0, rsp_tag}, 64'h7);
            chk("bp_req_ready", {62'd0, req_ready}, 64'd0);
        end
        step();
        rsp_ready = 1'b1;
        k = cyc;
        wait_drain();
        chk("bp_accept_edge", 64'(hs_log[$].e), 64'(k + 1));
        chk("bp_accept_id", {63'd0, hs_log[$].id}, 64'd1);
        chk("bp_rsp_edge", 64'(rsp_log[$].e), 64'(k + 3));
        chk("bp_rsp2_result", rsp_log[$].res, 64'h300);
        chk("bp_rsp2_tag", {60'd0, rsp_log[$].tag}, 64'h8);

        // Overflow, and both flags together
        step();
        push(0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 4'h3);
        wait_drain();
        chk("ovf_result", rsp_log[$].res, 64'h7FF0000000000000);
        chk("ovf_flags", {62'd0, rsp_log[$].ovf, rsp_log[$].unf}, 64'b10);
        step();
        push(1, 64'h3, 64'h7, 4'hA);
        wait_drain();
        chk("both_flags", {62'd0, rsp_log[$].ovf, rsp_log[$].unf}, 64'b11);
        chk("both_result", rsp_log[$].res, 64'hA);

        // Reset while in EXEC
        step();
        push(0, 64'h5, 64'h6, 4'h2);
        n = 0;
        do begin @(negedge clk); n++; end while (!(req_valid[0] && req_ready[0]) && n < 20);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rexec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rexec_busy", {63'd0, busy}, 64'd0);
        chk("rexec_add_a", add_a, 64'd0);
        chk("rexec_add_b", add_b, 64'd0);
        rb = rsp_log.size();
        hb = hs_log.size();
        step();
        push(0, 64'h1, 64'h1, 4'h4);
        push(1, 64'h2, 64'h2, 4'h5);
        wait_drain();
        chk("rexec_first_grant", {63'd0, hs_log[hb].id}, 64'd0);
        chk("rexec_rsp_count", 64'(rsp_log.size() - rb), 64'd2);

        // Idle stability
        step();
        repeat (10) begin
            @(negedge clk);
            chk("idle_req_ready", {62'd0, req_ready}, 64'd0);
            chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            chk("idle_busy", {63'd0, busy}, 64'd0);
            chk("idle_add_a", add_a, 64'h2);
            chk("idle_add_b", add_b, 64'h2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one combinational 64-bit FP adder (fpu_64_adder, instantiated outside this block) between two requesters.
- Arbitrates round-robin, registers operands into the adder, captures result and overflow/underflow flags, and returns them on a valid/ready response channel.
- Response carries the winning requester ID and a pass-through tag.
- Sits between the FPU issue logic and the shared adder datapath.

Parameters:
- WIDTH, 64, operand/result width; must match the adder.
- TAG_W, 4, width of the requester-supplied tag returned with the result.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req0_a, req0_b  input  WIDTH each  requester 0 operands.
- req1_a, req1_b  input  WIDTH each  requester 1 operands.
- req0_tag, req1_tag  input  TAG_W each  requester tags.
- add_a, add_b  output  WIDTH each  registered operands driven to the adder.
- add_result  input  WIDTH  adder result.
- add_overflow, add_underflow  input  1 each  adder flags.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  requester that owns the response.
- rsp_tag  output  TAG_W  tag of that request.
- rsp_result  output  WIDTH  captured sum.
- rsp_overflow, rsp_underflow  output  1 each  captured flags.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states are IDLE, EXEC and RESP. Reset forces IDLE.
- Reset values:
  - req_ready=0 (combinational, low because no request is valid in reset state).
  - add_a=add_b=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_overflow=rsp_underflow=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
- Accept window: IDLE, or RESP with rsp_ready=1.
- Grant (combinational):
  - If only one req_valid bit is set, that requester wins.
  - If both are set, the requester != last_grant wins.
  - If neither is set, there is no grant.
- req_ready[g] = accept_window && req_valid[g] for the granted g only. Otherwise 0.
- Handshake fires on req_valid[g] && req_ready[g] at a rising edge. On that edge:
  - add_a/add_b <= granted operands; id_r <= g; tag_r <= granted tag; last_grant <= g.
  - State goes to EXEC.
- EXEC (exactly 1 cycle; the adder settles on the registered operands):
  - At the edge: rsp_result <= add_result, rsp_overflow/underflow <= flags, rsp_id <= id_r, rsp_tag <= tag_r, rsp_valid <= 1.
  - State goes to RESP.
- RESP: rsp_valid=1 and all rsp_* held stable until rsp_ready=1. On the rsp_ready edge:
  - If a new request is accepted in the same cycle, go to EXEC; rsp_valid stays 0 for the EXEC cycle.
  - Otherwise rsp_valid <= 0 and state goes to IDLE.
- Latency: request handshake at edge N means rsp_valid is high from edge N+2. Back-to-back throughput is one result per 2 cycles.
- add_a/add_b hold their last value outside the handshake edge. No combinational path from req_* to add_*.
- A request not granted must keep valid and operands stable. The block never drops a presented valid request.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- rsp_ready has no effect in IDLE or EXEC.
- A request held while rsp_valid=1 and rsp_ready=0 waits. req_ready stays 0.
- Reset mid-operation (EXEC or RESP): in-flight result is discarded, all regs take reset values next edge, no response is issued.
- Flags pass through unmodified. Overflow and underflow may both be 1 if the adder reports so.

Test Plan:
- Single request: req0_a=0x3FF0000000000000 (1.0), req0_b=0x4000000000000000 (2.0), tag=0x5, valid at edge N, rsp_ready=1 -> rsp_valid high from N+2 for 1 cycle, rsp_result=0x4008000000000000 (3.0), rsp_id=0, rsp_tag=0x5, overflow=underflow=0.
- Contention: both valid continuously for 4 requests each, rsp_ready=1 -> grant order 0,1,0,1,… with first grant 0; one response every 2 cycles; tags match per ID.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, req1 pending -> rsp_* stable all 5 cycles, req_ready=0; on rsp_ready=1, req1 accepted the same edge and its response arrives 2 cycles later.
- Overflow: operands 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF -> rsp_overflow equals adder overflow output (1), result passed unmodified.
- Reset in EXEC: accept req0, assert rst on the next edge -> no rsp_valid, busy=0, add_a=add_b=0, next contention grants requester 0 first.
- Idle stability: no req_valid for 10 cycles -> req_ready=0, rsp_valid=0, busy=0, add_a/add_b unchanged.
